sort_rd_arbiter: RTL and testbench
==================================

SORT_RD_ARBITER -- requirements
Module: sort_rd_arbiter

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- NUM_REQ, 4: number of fetch requesters; power of 2.
- ID_WIDTH, 2: equals log2(NUM_REQ).
- ADDR_WIDTH, 64: address width.
- DATA_WIDTH, 1024: data width.
- ARUSER_WIDTH, 9: PASID width.
- MAX_OUTSTANDING, 8: per-requester outstanding burst limit, range 1..15.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: the single clock.
- rst_n, in, 1: asynchronous active-low reset.
- req_arvalid, in, NUM_REQ: per-requester read-address request.
- req_arready, out, NUM_REQ: per-requester accept.
- req_araddr, in, NUM_REQ*ADDR_WIDTH: flattened addresses; requester i at slice i.
- req_arlen, in, NUM_REQ*8: flattened burst lengths.
- req_aruser, in, NUM_REQ*ARUSER_WIDTH: flattened PASIDs.
- req_rvalid, out, NUM_REQ: per-requester read-data valid.
- req_rdata, out, DATA_WIDTH: read data broadcast to all requesters.
- req_rresp, out, 2: broadcast read response.
- req_rlast, out, 1: broadcast last beat.
- m_axi_arid, out, ID_WIDTH: index of the granted requester.
- m_axi_araddr, out, ADDR_WIDTH: latched address.
- m_axi_arlen, out, 8: latched burst length.
- m_axi_aruser, out, ARUSER_WIDTH: latched PASID.
- m_axi_arvalid, out, 1: address valid.
- m_axi_arready, in, 1: address ready.
- m_axi_arsize/arburst/arcache/arprot/arqos/arregion/arlock, out, 3/2/4/3/4/4/2: constants 7/1/3/0/0/0/0.
- m_axi_rid, in, ID_WIDTH: read ID.
- m_axi_rdata, in, DATA_WIDTH: read data.
- m_axi_rresp, in, 2: read response.
- m_axi_rlast, in, 1: last beat.
- m_axi_rvalid, in, 1: read valid.
- m_axi_rready, out, 1: constant 1.
- busy, out, 1: arbiter state or outstanding traffic non-idle.

Function
REQ-003 The block SHALL share one AXI read master between NUM_REQ requesters, using AXI ID = requester index.
REQ-004 The state machine SHALL have states IDLE and ISSUE.
REQ-005 Requester i SHALL be eligible when req_arvalid[i]=1 and outst[i] < MAX_OUTSTANDING.
REQ-006 In IDLE, the block SHALL grant the first eligible requester scanning round-robin from rr_ptr.
REQ-007 On a grant, req_arready[g] SHALL be 1 combinationally in that same cycle, and the block SHALL latch araddr/arlen/aruser/g, go to ISSUE, and set rr_ptr to (g+1) mod NUM_REQ.
REQ-008 req_arready SHALL be one-hot or zero and SHALL be zero in ISSUE.
REQ-009 In ISSUE, m_axi_arvalid SHALL be 1 with stable latched fields until m_axi_arready=1, then the state SHALL return to IDLE the next cycle.
- This gives a minimum of 2 cycles per address.
REQ-010 m_axi_arvalid SHALL be 0 in IDLE.
REQ-011 outst[g] SHALL increment on the ISSUE handshake (m_axi_arvalid & m_axi_arready), not at grant.
REQ-012 outst[rid] SHALL decrement on m_axi_rvalid & m_axi_rlast.
REQ-013 If an increment and a decrement of the same counter occur in one cycle, the counter SHALL be unchanged.
REQ-014 outst SHALL saturate: no increment beyond MAX_OUTSTANDING, no decrement below 0.
REQ-015 A decrement at 0 SHALL also raise sticky flag err_underflow (internal, visible to the bench).
REQ-016 req_rvalid[i] SHALL equal m_axi_rvalid & (m_axi_rid==i), combinationally with zero latency.
REQ-017 req_rdata, req_rresp and req_rlast SHALL pass m_axi_rdata/rresp/rlast through unchanged.
REQ-018 A non-OKAY rresp SHALL still be routed and SHALL still count rlast toward the decrement.
REQ-019 busy SHALL be (state==ISSUE) OR any outst nonzero.
REQ-020 Requesters SHALL hold req_arvalid and their fields until req_arready.
- The block does not buffer ungranted requests.

Reset
REQ-021 On rst_n=0, asynchronously: state SHALL be IDLE, rr_ptr 0, all outst 0, latched fields 0, err_underflow 0.
REQ-022 While rst_n=0: m_axi_arvalid 0, req_arready 0, busy 0.
REQ-023 Reset during ISSUE SHALL drop m_axi_arvalid immediately.
- R beats still in flight after reset SHALL be routed by rid but SHALL NOT decrement below 0.

Verification
REQ-024 Single request: req_arvalid=0001, addr 0x1000, arlen 0 -> req_arready[0] same cycle; next cycle arvalid=1, arid=0, araddr=0x1000; arready -> outst[0]=1; rvalid+rlast rid=0 -> req_rvalid=0001, outst[0]=0, busy=0.
REQ-025 Fairness: all four arvalid held, arready=1 -> grant order 0,1,2,3,0; one AR every 2 cycles.
REQ-026 Back-pressure: arready held 0 for 5 cycles in ISSUE -> arvalid/araddr/arid stable; no req_arready asserted.
REQ-027 Limit: requester 2 issues 8 un-returned bursts -> no further grant to 2 while requesters 0/1/3 still win; one rlast on rid=2 -> requester 2 eligible again.
REQ-028 Simultaneous: issue handshake and rlast for rid=1 in the same cycle with outst[1]=3 -> outst[1] stays 3.
REQ-029 Reset mid-ISSUE with outst=2/0/1/0 -> arvalid 0 immediately; all counters 0; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/sort_rd_arbiter.sv
// rtl/sort_rd_arbiter.sv - round-robin AR arbiter sharing one AXI read master, ID = requester index
module sort_rd_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ID_WIDTH        = 2,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 1024,
  parameter int ARUSER_WIDTH    = 9,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_arvalid,
  output logic [NUM_REQ-1:0]              req_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_araddr,
  input  logic [NUM_REQ*8-1:0]            req_arlen,
  input  logic [NUM_REQ*ARUSER_WIDTH-1:0] req_aruser,
  output logic [NUM_REQ-1:0]              req_rvalid,
  output logic [DATA_WIDTH-1:0]           req_rdata,
  output logic [1:0]                      req_rresp,
  output logic                            req_rlast,
  output logic [ID_WIDTH-1:0]             m_axi_arid,
  output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
  output logic [7:0]                      m_axi_arlen,
  output logic [ARUSER_WIDTH-1:0]         m_axi_aruser,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  output logic [2:0]                      m_axi_arsize,
  output logic [1:0]                      m_axi_arburst,
  output logic [3:0]                      m_axi_arcache,
  output logic [2:0]                      m_axi_arprot,
  output logic [3:0]                      m_axi_arqos,
  output logic [3:0]                      m_axi_arregion,
  output logic [1:0]                      m_axi_arlock,
  input  logic [ID_WIDTH-1:0]             m_axi_rid,
  input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rlast,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  output logic                            busy
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                          state_q, state_d;
  logic [ID_WIDTH-1:0]             rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]             gnt_id_q, gnt_id_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [7:0]                      len_q, len_d;
  logic [ARUSER_WIDTH-1:0]         user_q, user_d;
  logic [NUM_REQ-1:0][CNT_W-1:0]   outst_q, outst_d;
  logic                            err_underflow_q, err_underflow_d;

  logic [NUM_REQ-1:0]              eligible;
  logic                            gnt_valid;
  logic [ID_WIDTH-1:0]             gnt_idx;
  logic                            ar_hs;
  logic                            r_done;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_arvalid[i] && (outst_q[i] < MAX_CNT);
    end
  end

  // First eligible requester at or after rr_ptr; wrap relies on NUM_REQ being a power of 2.
  always_comb begin : rr_scan
    logic [ID_WIDTH-1:0] idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr_q + ID_WIDTH'(k);
      if (!gnt_valid && eligible[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    user_d      = user_q;
    req_arready = '0;
    case (state_q)
      IDLE: begin
        if (gnt_valid && rst_n) begin
          req_arready[gnt_idx] = 1'b1;
          gnt_id_d = gnt_idx;
          addr_d   = req_araddr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          len_d    = req_arlen[int'(gnt_idx)*8 +: 8];
          user_d   = req_aruser[int'(gnt_idx)*ARUSER_WIDTH +: ARUSER_WIDTH];
          rr_ptr_d = gnt_idx + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (m_axi_arready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ar_hs  = (state_q == ISSUE) && m_axi_arready;
  assign r_done = m_axi_rvalid && m_axi_rlast;

  // Issue and completion on the same counter in one cycle cancel out.
  always_comb begin : cnt_upd
    logic inc;
    logic dec;
    outst_d         = outst_q;
    err_underflow_d = err_underflow_q;
    inc             = 1'b0;
    dec             = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc = ar_hs && (gnt_id_q == ID_WIDTH'(i));
      dec = r_done && (m_axi_rid == ID_WIDTH'(i));
      if (inc && !dec) begin
        if (outst_q[i] != MAX_CNT) outst_d[i] = outst_q[i] + 1'b1;
      end else if (dec && !inc) begin
        if (outst_q[i] == '0) err_underflow_d = 1'b1;
        else                  outst_d[i] = outst_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      gnt_id_q        <= '0;
      addr_q          <= '0;
      len_q           <= '0;
      user_q          <= '0;
      outst_q         <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      gnt_id_q        <= gnt_id_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      user_q          <= user_d;
      outst_q         <= outst_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  always_comb begin
    req_rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rvalid[i] = m_axi_rvalid && (m_axi_rid == ID_WIDTH'(i));
    end
  end

  assign req_rdata      = m_axi_rdata;
  assign req_rresp      = m_axi_rresp;
  assign req_rlast      = m_axi_rlast;

  assign m_axi_arvalid  = (state_q == ISSUE);
  assign m_axi_arid     = gnt_id_q;
  assign m_axi_araddr   = addr_q;
  assign m_axi_arlen    = len_q;
  assign m_axi_aruser   = user_q;
  assign m_axi_arsize   = 3'd7;
  assign m_axi_arburst  = 2'd1;
  assign m_axi_arcache  = 4'd3;
  assign m_axi_arprot   = 3'd0;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;
  assign m_axi_arlock   = 2'd0;
  assign m_axi_rready   = 1'b1;

  assign busy = (state_q == ISSUE) || (outst_q != '0);

endmodule

// File: tb/tb_sort_rd_arbiter.sv
// tb/tb_sort_rd_arbiter.sv - scoreboard bench for sort_rd_arbiter
module tb_sort_rd_arbiter;
  localparam int NR = 4, IDW = 2, AW = 64, DW = 1024, UW = 9, MO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NR-1:0]     req_arvalid, req_arready, req_rvalid;
  logic [NR*AW-1:0]  req_araddr;
  logic [NR*8-1:0]   req_arlen;
  logic [NR*UW-1:0]  req_aruser;
  logic [DW-1:0]     req_rdata, m_axi_rdata;
  logic [1:0]        req_rresp, m_axi_rresp;
  logic              req_rlast, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [IDW-1:0]    m_axi_arid, m_axi_rid;
  logic [AW-1:0]     m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [UW-1:0]     m_axi_aruser;
  logic              m_axi_arvalid, m_axi_arready, busy;
  logic [2:0]        m_axi_arsize, m_axi_arprot;
  logic [1:0]        m_axi_arburst, m_axi_arlock;
  logic [3:0]        m_axi_arcache, m_axi_arqos, m_axi_arregion;

  sort_rd_arbiter #(
    .NUM_REQ(NR), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ARUSER_WIDTH(UW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_arvalid(req_arvalid), .req_arready(req_arready), .req_araddr(req_araddr),
    .req_arlen(req_arlen), .req_aruser(req_aruser), .req_rvalid(req_rvalid),
    .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_aruser(m_axi_aruser), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion),
    .m_axi_arlock(m_axi_arlock), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [82:0] exp_ar [$];   // {id, addr, len, user}
  logic [70:0] exp_r  [$];   // {rvalid mask, data, resp, last}
  int          hs_cyc [$];
  logic [80:0] rq [NR][$];   // per-requester pending {addr, len, user}
  logic [82:0] mon_ar;
  logic [70:0] mon_r;
  logic [NR-1:0] acc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Requesters hold their front request until accepted.
  initial begin
    req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_aruser = '0;
    forever begin
      for (int i = 0; i < NR; i++) begin
        if (rq[i].size() > 0) begin
          req_arvalid[i] = 1'b1;
          {req_araddr[i*AW +: AW], req_arlen[i*8 +: 8], req_aruser[i*UW +: UW]} = rq[i][0];
        end else begin
          req_arvalid[i] = 1'b0;
        end
      end
      @(negedge clk);
      acc = req_arready;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++)
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (m_axi_arvalid && m_axi_arready) begin
        hs_cyc.push_back(cyc);
        if (exp_ar.size() == 0) begin
          total++; bad++;
          $display("FAIL ar_unexpected actual id=%0d addr=0x%0h required=none", m_axi_arid, m_axi_araddr);
        end else begin
          mon_ar = exp_ar.pop_front();
          chk("ar_fields", {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_aruser}, mon_ar);
        end
      end
      if (|req_rvalid) begin
        if (exp_r.size() == 0) begin
          total++; bad++;
          $display("FAIL r_unexpected actual mask=%b required=none", req_rvalid);
        end else begin
          mon_r = exp_r.pop_front();
          chk("r_route", {req_rvalid, req_rresp, req_rlast}, {mon_r[70:67], mon_r[2:0]});
          chk("r_data_lo", req_rdata[127:0], {2{mon_r[66:3]}});
          chk("r_data_hi", req_rdata[DW-1:DW-64], mon_r[66:3]);
        end
      end
      chk("arready_onehot0", $onehot0(req_arready), 1);
      chk("arready_in_issue", m_axi_arvalid && (|req_arready), 0);
    end
  end

  task automatic push_req(input int id, input logic [63:0] a, input logic [7:0] l,
                          input logic [8:0] u, input bit expect_ar);
    rq[id].push_back({a, l, u});
    if (expect_ar) exp_ar.push_back({IDW'(id), a, l, u});
  endtask

  task automatic r_beat(input int id, input logic [1:0] resp, input logic last, input logic [63:0] d);
    @(posedge clk); #1;
    exp_r.push_back({4'(1 << id), d, resp, last});
    m_axi_rvalid = 1'b1; m_axi_rid = IDW'(id); m_axi_rdata = {16{d}};
    m_axi_rresp = resp; m_axi_rlast = last;
    @(posedge clk); #1;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
  endtask

  task automatic wait_arvalid(input string name);
    int n = 0;
    @(negedge clk);
    while (m_axi_arvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk(name, m_axi_arvalid, 1);
  endtask

  task automatic wait_ar_drain(input string name);
    int n = 0;
    while (exp_ar.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk(name, exp_ar.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rid = '0;
    m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outst", dut.outst_q, 0);
    chk("rst_err", dut.err_underflow_q, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("const_ar", {m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot,
                     m_axi_arqos, m_axi_arregion, m_axi_arlock, m_axi_rready},
                    {3'd7, 2'd1, 4'd3, 3'd0, 4'd0, 4'd0, 2'd0, 1'b1});

    // single request
    push_req(0, 64'h1000, 8'd0, 9'h005, 1);
    @(negedge clk);
    chk("rst_arready_held", req_arready, 0);
    @(posedge clk); #1; rst_n = 1'b1; m_axi_arready = 1'b1;
    @(negedge clk);
    chk("t1_grant", req_arready, 4'b0001);
    chk("t1_idle_arvalid", m_axi_arvalid, 0);
    @(negedge clk);
    chk("t1_issue", {m_axi_arvalid, m_axi_arid, m_axi_araddr}, {1'b1, 2'd0, 64'h1000});
    @(negedge clk);
    chk("t1_outst0", dut.outst_q[0], 1);
    chk("t1_busy", busy, 1);
    r_beat(0, 2'b00, 1'b1, 64'hD000_0000_0000_0001);
    @(negedge clk);
    chk("t1_outst0_ret", dut.outst_q[0], 0);
    chk("t1_idle_busy", busy, 0);

    // back-pressure
    @(posedge clk); #1; m_axi_arready = 1'b0;
    @(negedge clk);
    push_req(1, 64'h2000, 8'd3, 9'h011, 1);
    push_req(3, 64'h3000, 8'd0, 9'h033, 1);
    wait_arvalid("t2_issue");
    repeat (5) begin
      @(negedge clk);
      chk("t2_hold", {m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen}, {1'b1, 2'd1, 64'h2000, 8'd3});
      chk("t2_no_arready", req_arready, 0);
    end
    @(posedge clk); #1; m_axi_arready = 1'b1;
    wait_ar_drain("t2_drain");
    @(negedge clk);
    chk("t2_outst", {dut.outst_q[1], dut.outst_q[3]}, {4'd1, 4'd1});
    r_beat(1, 2'b00, 1'b0, 64'hD000_0000_0000_0002);
    @(negedge clk);
    chk("t2_nonlast_keep", dut.outst_q[1], 1);
    r_beat(1, 2'b00, 1'b1, 64'hD000_0000_0000_0003);
    r_beat(3, 2'b10, 1'b1, 64'hD000_0000_0000_0004);
    @(negedge clk);
    chk("t2_outst_ret", {dut.outst_q[1], dut.outst_q[3]}, 0);
    chk("t2_busy", busy, 0);

    // simultaneous issue and completion on requester 1
    @(negedge clk);
    for (int k = 0; k < 3; k++) push_req(1, 64'h4000 + 64'(k * 256), 8'd1, 9'h011, 1);
    wait_ar_drain("t3_fill");
    @(negedge clk);
    chk("t3_outst1_3", dut.outst_q[1], 3);
    @(posedge clk); #1; m_axi_arready = 1'b0;
    @(negedge clk);
    push_req(1, 64'h4300, 8'd1, 9'h011, 1);
    wait_arvalid("t3_issue");
    @(posedge clk); #1;
    m_axi_arready = 1'b1;
    exp_r.push_back({4'b0010, 64'hD000_0000_0000_0005, 2'b00, 1'b1});
    m_axi_rvalid = 1'b1; m_axi_rid = 2'd1; m_axi_rdata = {16{64'hD000_0000_0000_0005}};
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b1;
    @(posedge clk); #1; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    @(negedge clk);
    chk("t3_outst1_same", dut.outst_q[1], 3);
    repeat (3) r_beat(1, 2'b00, 1'b1, 64'hD000_0000_0000_0006);
    @(negedge clk);
    chk("t3_outst1_ret", dut.outst_q[1], 0);

    // outstanding limit on requester 2
    @(negedge clk);
    for (int k = 0; k < 8; k++) push_req(2, 64'h8000 + 64'(k * 64), 8'd7, 9'h022, 1);
    wait_ar_drain("t4_fill");
    @(negedge clk);
    chk("t4_outst2_max", dut.outst_q[2], 8);
    push_req(2, 64'h8900, 8'd7, 9'h022, 0);
    push_req(3, 64'h9300, 8'd0, 9'h033, 1);
    push_req(0, 64'h9000, 8'd0, 9'h005, 1);
    push_req(1, 64'h9100, 8'd0, 9'h011, 1);
    wait_ar_drain("t4_others");
    repeat (4) begin
      @(negedge clk);
      chk("t4_blocked", {m_axi_arvalid, req_arready}, 0);
    end
    chk("t4_outst2_hold", dut.outst_q[2], 8);
    exp_ar.push_back({2'd2, 64'h8900, 8'd7, 9'h022});
    r_beat(2, 2'b00, 1'b1, 64'hD000_0000_0000_0007);
    wait_ar_drain("t4_resume");
    @(negedge clk);
    chk("t4_outst2_again", dut.outst_q[2], 8);

    // reset mid-ISSUE with outst = 2/0/1/0
    r_beat(1, 2'b00, 1'b1, 64'hD000_0000_0000_0008);
    r_beat(3, 2'b00, 1'b1, 64'hD000_0000_0000_0009);
    repeat (7) r_beat(2, 2'b00, 1'b1, 64'hD000_0000_0000_000A);
    @(negedge clk);
    push_req(0, 64'hA000, 8'd0, 9'h005, 1);
    wait_ar_drain("t5_fill");
    @(negedge clk);
    chk("t5_outst_pre", dut.outst_q, {4'd0, 4'd1, 4'd0, 4'd2});
    @(posedge clk); #1; m_axi_arready = 1'b0;
    @(negedge clk);
    push_req(3, 64'hB000, 8'd0, 9'h033, 0);
    wait_arvalid("t5_issue");
    @(posedge clk); #3; rst_n = 1'b0; #1;
    chk("t5_rst_arvalid", m_axi_arvalid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_outst", dut.outst_q, 0);
    chk("t5_rst_fields", {m_axi_arid, m_axi_araddr, req_arready}, 0);
    m_axi_arready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_n = 1'b1;
    r_beat(2, 2'b00, 1'b1, 64'hD000_0000_0000_000B);
    @(negedge clk);
    chk("t5_no_underflow", dut.outst_q[2], 0);
    chk("t5_err_flag", dut.err_underflow_q, 1);

    // fairness from rr_ptr = 0
    hs_cyc.delete();
    @(negedge clk);
    push_req(0, 64'hC000, 8'd0, 9'h005, 1);
    push_req(1, 64'hC100, 8'd0, 9'h011, 1);
    push_req(2, 64'hC200, 8'd0, 9'h022, 1);
    push_req(3, 64'hC300, 8'd0, 9'h033, 1);
    push_req(0, 64'hC400, 8'd0, 9'h005, 1);
    wait_ar_drain("t6_drain");
    chk("t6_hs_count", hs_cyc.size(), 5);
    if (hs_cyc.size() >= 5)
      for (int k = 0; k < 4; k++) chk("t6_spacing", hs_cyc[k+1] - hs_cyc[k], 2);

    repeat (2) @(negedge clk);
    chk("end_exp_r_empty", exp_r.size(), 0);
    chk("end_exp_ar_empty", exp_ar.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
